seg_scan_ctrl: RTL and testbench

//   Scan controller for the board's two 4-digit 7-segment groups (shared buses
//   a_to_g_left/a_to_g_right, digit selects leftseg/rightseg). Holds an 8-digit
//   hex frame written over a valid/ready port and decodes it to segments.

---
 rtl/seg_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Two-group 4-digit 7-segment scan controller.
// Double-buffered hex frame, blanking gap per slot, tear-free frame commits.
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  wr_mask,
  output logic [3:0]  leftseg,
  output logic [3:0]  rightseg,
  output logic [7:0]  a_to_g_left,
  output logic [7:0]  a_to_g_right,
  output logic        frame_start
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  localparam state_t SLOT0 = (BLANK == 0) ? S_SHOW : S_BLANK;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BL = CW'((BLANK > 0) ? BLANK - 1 : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    p, p_n;

  logic [31:0] pend_data, act_data;
  logic [7:0]  pend_dp, act_dp;
  logic [7:0]  pend_mask, act_mask;
  logic        accept, commit;

  logic [3:0] rs_d, ls_d;
  logic [7:0] sr_d, sl_d;
  logic       fs_d;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      p     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p     <= p_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_n     = p;
    if (!en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      p_n     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = SLOT0;
          cnt_n   = '0;
          p_n     = '0;
        end
        S_BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_BL) state_n = S_SHOW;
        end
        S_SHOW: begin
          if (cnt == CNT_LAST) begin
            state_n = SLOT0;
            cnt_n   = '0;
            p_n     = p + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          p_n     = '0;
        end
      endcase
    end
  end

  always_comb begin
    rs_d = '0;
    ls_d = '0;
    sr_d = '0;
    sl_d = '0;
    fs_d = (state != S_IDLE) && (p == 2'd0) && (cnt == '0);
    if (state == S_SHOW) begin
      rs_d[p] = act_mask[{1'b0, p}];
      ls_d[p] = act_mask[{1'b1, p}];
      if (act_mask[{1'b0, p}])
        sr_d = {act_dp[{1'b0, p}], hex7(act_data[{1'b0, p, 2'b00} +: 4])};
      if (act_mask[{1'b1, p}])
        sl_d = {act_dp[{1'b1, p}], hex7(act_data[{1'b1, p, 2'b00} +: 4])};
    end
  end

  assign accept = wr_valid & wr_ready;
  // commit on the edge that enters a new frame, so the whole frame sees one buffer
  assign commit = (state == S_IDLE) ||
                  (en && state == S_SHOW && cnt == CNT_LAST && p == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_mask    <= '0;
      act_data     <= '0;
      act_dp       <= '0;
      act_mask     <= '0;
      wr_ready     <= 1'b1;
      rightseg     <= '0;
      leftseg      <= '0;
      a_to_g_right <= '0;
      a_to_g_left  <= '0;
      frame_start  <= 1'b0;
    end else begin
      if (commit) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_mask <= pend_mask;
      end
      if (accept) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        pend_mask <= wr_mask;
      end
      wr_ready     <= commit ? ~accept : (wr_ready & ~accept);
      rightseg     <= rs_d;
      leftseg      <= ls_d;
      a_to_g_right <= sr_d;
      a_to_g_left  <= sl_d;
      frame_start  <= fs_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8, BLANK=2.
// Pin-time t counts cycles from the last observed frame_start.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  wr_mask;
  logic [3:0]  leftseg, rightseg;
  logic [7:0]  a_to_g_left, a_to_g_right;
  logic        frame_start;

  seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_dp(wr_dp),
    .wr_mask(wr_mask),
    .leftseg(leftseg),
    .rightseg(rightseg),
    .a_to_g_left(a_to_g_left),
    .a_to_g_right(a_to_g_right),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic       en;
    logic [3:0] rs;
    logic [3:0] ls;
    logic [7:0] sr;
    logic [7:0] sl;
    logic       fs;
  } vec_t;

  int ntests = 0;
  int nfail = 0;
  int t = 0;
  vec_t tab[11];

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int target);
    while (t < target) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_pins(input string nm, input logic [3:0] rs,
                          input logic [3:0] ls, input logic [7:0] sr,
                          input logic [7:0] sl);
    chk(nm, {8'h0, rightseg, leftseg, a_to_g_right, a_to_g_left},
        {8'h0, rs, ls, sr, sl});
  endtask

  task automatic wait_fs(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (frame_start === 1'b1) break;
    end
    chk({nm, "_fs_seen"}, {31'h0, frame_start}, 32'h1);
    t = 0;
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp,
                       input logic [7:0] m);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_dp    = dp;
    wr_mask  = m;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    logic bad;
    tab[0]  = '{0,  1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1};
    tab[1]  = '{1,  1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0};
    tab[2]  = '{2,  1'b1, 4'h1, 4'h1, 8'h3F, 8'h66, 1'b0};
    tab[3]  = '{7,  1'b1, 4'h1, 4'h1, 8'h3F, 8'h66, 1'b0};
    tab[4]  = '{8,  1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0};
    tab[5]  = '{9,  1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0};
    tab[6]  = '{10, 1'b1, 4'h2, 4'h2, 8'h06, 8'h6D, 1'b0};
    tab[7]  = '{18, 1'b1, 4'h4, 4'h4, 8'h5B, 8'h7D, 1'b0};
    tab[8]  = '{26, 1'b1, 4'h8, 4'h8, 8'h4F, 8'h07, 1'b0};
    tab[9]  = '{31, 1'b1, 4'h8, 4'h8, 8'h4F, 8'h07, 1'b0};
    tab[10] = '{32, 1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1};

    rst = 1'b1;
    en = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_dp = '0;
    wr_mask = '0;

    // 1. reset state, then scanning an empty (all-masked) frame
    tick();
    tick();
    chk_pins("reset_pins", 4'h0, 4'h0, 8'h00, 8'h00);
    chk("reset_fs", {31'h0, frame_start}, 32'h0);
    chk("reset_ready", {31'h0, wr_ready}, 32'h1);
    rst = 1'b0;
    en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rightseg !== 4'h0 || leftseg !== 4'h0) bad = 1'b1;
    end
    chk("empty_sel_zero", {31'h0, bad}, 32'h0);

    // 2. load a frame while idle, then scan it
    en = 1'b0;
    tick();
    tick();
    write(32'h76543210, 8'h00, 8'hFF);
    chk("idle_wr_busy", {31'h0, wr_ready}, 32'h0);
    tick();
    chk("idle_commit_ready", {31'h0, wr_ready}, 32'h1);
    en = 1'b1;
    wait_fs("f1", 6);
    foreach (tab[i]) begin
      goto(tab[i].t);
      en = tab[i].en;
      chk_pins($sformatf("scan_t%0d", tab[i].t),
               tab[i].rs, tab[i].ls, tab[i].sr, tab[i].sl);
      chk($sformatf("fs_t%0d", tab[i].t),
          {31'h0, frame_start}, {31'h0, tab[i].fs});
    end

    // 3. mid-frame write waits for the frame boundary; busy writes dropped
    goto(40);
    write(32'hFFFFFFFF, 8'h00, 8'hFF);
    chk("mid_wr_busy", {31'h0, wr_ready}, 32'h0);
    write(32'h00000000, 8'h00, 8'hFF);
    goto(50);
    chk_pins("old_frame_kept", 4'h4, 4'h4, 8'h5B, 8'h7D);
    goto(62);
    chk("busy_until_frame", {31'h0, wr_ready}, 32'h0);
    goto(63);
    chk("ready_at_commit", {31'h0, wr_ready}, 32'h1);
    goto(64);
    chk("fs_t64", {31'h0, frame_start}, 32'h1);
    t = 0;
    goto(2);
    chk_pins("new_frame_F", 4'h1, 4'h1, 8'h71, 8'h71);
    goto(18);
    chk_pins("new_frame_F_p2", 4'h4, 4'h4, 8'h71, 8'h71);

    // 4. partial mask and decimal point
    goto(20);
    write(32'h76543210, 8'h01, 8'h0F);
    wait_fs("f4", 20);
    goto(2);
    chk_pins("mask_dp_p0", 4'h1, 4'h0, 8'hBF, 8'h00);
    goto(26);
    chk_pins("mask_p3", 4'h8, 4'h0, 8'h4F, 8'h00);

    // 5. disable mid-SHOW, then restart
    wait_fs("f5", 40);
    goto(12);
    en = 1'b0;
    tick();
    tick();
    chk_pins("en_off_pins", 4'h0, 4'h0, 8'h00, 8'h00);
    tick();
    chk("en_off_fs", {31'h0, frame_start}, 32'h0);
    en = 1'b1;
    wait_fs("restart", 4);
    chk_pins("restart_blank", 4'h0, 4'h0, 8'h00, 8'h00);
    goto(2);
    chk_pins("restart_p0", 4'h1, 4'h0, 8'hBF, 8'h00);

    // 6. reset discards a pending frame
    goto(5);
    write(32'h88888888, 8'hFF, 8'hFF);
    chk("pend_busy", {31'h0, wr_ready}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'h0, wr_ready}, 32'h1);
    chk_pins("rst_pins", 4'h0, 4'h0, 8'h00, 8'h00);
    wait_fs("post_rst", 6);
    goto(2);
    chk_pins("rst_discard_p0", 4'h0, 4'h0, 8'h00, 8'h00);
    goto(34);
    chk_pins("rst_discard_f2", 4'h0, 4'h0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
